// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared types and sizes for the data memory arbiter
package data_mem_arbiter_pkg;
  localparam int DMEM_AW = 5;
  localparam int DMEM_DW = 16;
  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_e;
  typedef struct packed {
    logic req;
    logic we;
    logic [DMEM_AW-1:0] adr;
    logic [DMEM_DW-1:0] wdata;
  } mem_req_s;
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: requester and memory-side bus of the data memory arbiter
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int DW = DMEM_DW,
  parameter int AW = DMEM_AW
);
  logic [1:0] req;
  logic [1:0] we;
  logic [AW-1:0] adr0;
  logic [AW-1:0] adr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0] gnt;
  logic [1:0] rvalid;
  logic [DW-1:0] rdata;
  logic mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input req, we, adr0, adr1, wdata0, wdata1, mem_rdata,
    output gnt, rvalid, rdata, mem_we, mem_adr, mem_wdata
  );
  modport master (
    output req, we, adr0, adr1, wdata0, wdata1, mem_rdata,
    input gnt, rvalid, rdata, mem_we, mem_adr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin winner, the port that did not own last wins a tie
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       any
);
  // tie goes away from the last owner, otherwise the lone requester wins
  always_comb begin
    any = |req;
    winner = &req ? ~last_owner : req[1];
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin, burst-bounded sharing of one memory port between two requesters
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DW = DMEM_DW,
  parameter int AW = DMEM_AW,
  parameter int BURST_MAX = 4
) (
  input logic clk_i,
  input logic rst,
  data_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(BURST_MAX + 1);
  arb_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic last_owner, last_nxt;
  logic winner, any, busy, own, beat, other, at_max;
  mem_req_s sel;
  rr_pick2 u_pick (
    .req(bus.req),
    .last_owner(last_owner),
    .winner(winner),
    .any(any)
  );
  // memory mux, Moore grant and ownership/burst next-state
  always_comb begin
    busy = state != ARB_IDLE;
    own = state == ARB_OWN1;
    sel.req = bus.req[own];
    sel.we = bus.we[own];
    sel.adr = own ? bus.adr1 : bus.adr0;
    sel.wdata = own ? bus.wdata1 : bus.wdata0;
    beat = busy & sel.req;
    other = bus.req[~own];
    at_max = cnt == CW'(BURST_MAX - 1);
    bus.gnt = {state == ARB_OWN1, state == ARB_OWN0};
    bus.mem_we = beat & sel.we;
    bus.mem_adr = busy ? sel.adr : '0;
    bus.mem_wdata = busy ? sel.wdata : '0;
    state_nxt = state;
    cnt_nxt = '0;
    last_nxt = last_owner;
    if (!busy) begin
      state_nxt = any ? (winner ? ARB_OWN1 : ARB_OWN0) : ARB_IDLE;
    end else if (!sel.req) begin
      state_nxt = other ? (own ? ARB_OWN0 : ARB_OWN1) : ARB_IDLE;
    end else begin
      last_nxt = own;
      cnt_nxt = at_max ? '0 : cnt + 1'b1;
      if (at_max && other) state_nxt = own ? ARB_OWN0 : ARB_OWN1;
    end
  end
  // ownership state, burst count and tie-break history
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
      cnt <= '0;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      last_owner <= last_nxt;
    end
  end
  // read return: capture memory data on a read beat, rdata holds otherwise
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      bus.rvalid <= '0;
      bus.rdata <= '0;
    end else begin
      bus.rvalid <= (beat && !sel.we) ? (own ? 2'b10 : 2'b01) : 2'b00;
      if (beat && !sel.we) bus.rdata <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_data_mem_arbiter;
  localparam int BURST_MAX = 4;
  logic clk_i = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  int owner, burst, last;
  logic [1:0] exp_rvalid;
  logic [15:0] exp_rdata;
  logic [15:0] mem [32];
  logic [15:0] ref_mem [32];
  int rv0, rv1;
  data_mem_arbiter_if #(.DW(16), .AW(5)) bus ();
  data_mem_arbiter #(.DW(16), .AW(5), .BURST_MAX(BURST_MAX)) dut (
    .clk_i(clk_i),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  assign bus.mem_rdata = mem[bus.mem_adr];
  always @(posedge clk_i) if (bus.mem_we) mem[bus.mem_adr] <= bus.mem_wdata;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    owner = -1;
    burst = 0;
    last = 1;
    exp_rvalid = 2'b00;
    exp_rdata = 16'h0;
  endtask
  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1);
    bus.req = r;
    bus.we = w;
    bus.adr0 = a0;
    bus.adr1 = a1;
    bus.wdata0 = d0;
    bus.wdata1 = d1;
  endtask
  task automatic step();
    int o;
    logic [1:0] r, w;
    logic [4:0] a;
    logic [15:0] d;
    #1;
    o = owner < 0 ? 0 : owner;
    r = bus.req;
    w = bus.we;
    a = o == 1 ? bus.adr1 : bus.adr0;
    d = o == 1 ? bus.wdata1 : bus.wdata0;
    chk("gnt", bus.gnt, owner < 0 ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10));
    chk("mem_we", bus.mem_we, owner >= 0 && r[o] && w[o]);
    chk("mem_adr", bus.mem_adr, owner < 0 ? 5'd0 : a);
    chk("mem_wdata", bus.mem_wdata, owner < 0 ? 16'd0 : d);
    chk("rvalid", bus.rvalid, exp_rvalid);
    chk("rdata", bus.rdata, exp_rdata);
    rv0 += int'(bus.rvalid[0]);
    rv1 += int'(bus.rvalid[1]);
    @(posedge clk_i);
    exp_rvalid = 2'b00;
    if (owner < 0) begin
      if (r != 2'b00) owner = r == 2'b11 ? 1 - last : int'(r[1]);
      burst = 0;
    end else if (r[o]) begin
      if (w[o]) ref_mem[a] = d;
      else begin
        exp_rvalid = o == 1 ? 2'b10 : 2'b01;
        exp_rdata = ref_mem[a];
      end
      last = o;
      burst++;
      if (burst == BURST_MAX) begin
        burst = 0;
        if (r[1-o]) owner = 1 - o;
      end
    end else begin
      owner = r[1-o] ? 1 - o : -1;
      burst = 0;
    end
    @(negedge clk_i);
  endtask
  task automatic do_reset();
    drive(2'b00, 2'b00, 5'd0, 5'd0, 16'd0, 16'd0);
    rst = 1'b0;
    #1;
    @(negedge clk_i);
    rst = 1'b1;
    model_reset();
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    mem[7] = 16'h1234;
    ref_mem[7] = 16'h1234;
    model_reset();
    rv0 = 0;
    rv1 = 0;
    drive(2'b00, 2'b00, 5'd0, 5'd0, 16'd0, 16'd0);
    #12;
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_rvalid", bus.rvalid, 2'b00);
    chk("rst_rdata", bus.rdata, 16'h0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_adr", bus.mem_adr, 5'd0);
    @(negedge clk_i);
    rst = 1'b1;
    drive(2'b01, 2'b01, 5'd3, 5'd0, 16'hA5A5, 16'h0);
    #1 chk("a_gnt_latency", bus.gnt, 2'b00);
    step();
    #1 chk("a_gnt", bus.gnt, 2'b01);
    chk("a_mem_we", bus.mem_we, 1'b1);
    chk("a_mem_adr", bus.mem_adr, 5'd3);
    step();
    drive(2'b01, 2'b00, 5'd3, 5'd0, 16'h0, 16'h0);
    step();
    drive(2'b00, 2'b00, 5'd0, 5'd0, 16'h0, 16'h0);
    #1 chk("a_rvalid", bus.rvalid, 2'b01);
    chk("a_rdata", bus.rdata, 16'hA5A5);
    step();
    do_reset();
    drive(2'b11, 2'b00, 5'd1, 5'd2, 16'h0, 16'h0);
    step();
    #1 chk("b_first_port0", bus.gnt, 2'b01);
    step();
    drive(2'b10, 2'b00, 5'd1, 5'd2, 16'h0, 16'h0);
    step();
    #1 chk("b_no_bubble", bus.gnt, 2'b10);
    step();
    drive(2'b00, 2'b00, 5'd0, 5'd0, 16'h0, 16'h0);
    step();
    do_reset();
    drive(2'b11, 2'b00, 5'd4, 5'd5, 16'h0, 16'h0);
    step();
    for (int i = 0; i < 16; i++) begin
      #1 chk("c_alternate", bus.gnt, ((i / 4) % 2) == 1 ? 2'b10 : 2'b01);
      step();
    end
    drive(2'b00, 2'b00, 5'd0, 5'd0, 16'h0, 16'h0);
    step();
    step();
    rv0 = 0;
    rv1 = 0;
    drive(2'b10, 2'b00, 5'd0, 5'd7, 16'h0, 16'h0);
    step();
    for (int i = 0; i < 10; i++) begin
      #1 chk("d_gnt_held", bus.gnt, 2'b10);
      step();
    end
    drive(2'b00, 2'b00, 5'd0, 5'd0, 16'h0, 16'h0);
    step();
    chk("d_rv1_beats", rv1, 10);
    chk("d_rv0_never", rv0, 0);
    chk("d_rdata", bus.rdata, 16'h1234);
    do_reset();
    drive(2'b01, 2'b00, 5'd3, 5'd0, 16'h0, 16'h0);
    step();
    step();
    drive(2'b01, 2'b01, 5'd3, 5'd0, 16'hBEEF, 16'h0);
    #1 chk("e_pending_rvalid", bus.rvalid, 2'b01);
    chk("e_setup_we", bus.mem_we, 1'b1);
    #2 rst = 1'b0;
    #1 chk("e_async_gnt", bus.gnt, 2'b00);
    chk("e_async_we", bus.mem_we, 1'b0);
    chk("e_async_rvalid", bus.rvalid, 2'b00);
    @(posedge clk_i);
    @(negedge clk_i);
    rst = 1'b1;
    model_reset();
    chk("e_write_lost", mem[3], 16'hA5A5);
    drive(2'b11, 2'b00, 5'd3, 5'd7, 16'h0, 16'h0);
    step();
    #1 chk("e_port0_wins", bus.gnt, 2'b01);
    step();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0) ? 2'($urandom) : 2'b00, 2'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 16'($urandom));
      step();
    end
    drive(2'b00, 2'b00, 5'd0, 5'd0, 16'h0, 16'h0);
    step();
    for (int i = 0; i < 32; i++) chk("mem_final", mem[i], ref_mem[i]);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
